// File: rtl/sram_pkg.sv
// Shared SRAM bus definitions used by the controller and the device-side responder.
package sram_pkg;
  localparam int SRAM_ADDR_W   = 18;
  localparam int SRAM_DATA_W   = 16;
  localparam int SRAM_LANES    = 2;
  localparam int ERR_WR_NOLANE = 0;
  localparam int ERR_RD_NOLANE = 1;
  localparam int ERR_WE_NOCE   = 2;
endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency shift register: valid/lane-mask/data per stage, never stalls.
// flush drops every in-flight entry at the next edge; rst clears valids asynchronously.
module sram_rd_pipe import sram_pkg::*; #(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [SRAM_LANES-1:0] in_mask,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  output logic [SRAM_LANES-1:0] out_mask,
  output logic [DATA_W-1:0]     out_data
);

  logic [DEPTH-1:0]      valid_reg;
  logic [SRAM_LANES-1:0] mask_reg [DEPTH];
  logic [DATA_W-1:0]     data_reg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid_reg[i] <= valid_reg[i-1];
    end
  end

  // Payload needs no reset; it is qualified by valid_reg everywhere.
  always_ff @(posedge clk) begin
    mask_reg[0] <= in_mask;
    data_reg[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) begin
      mask_reg[i] <= mask_reg[i-1];
      data_reg[i] <= data_reg[i-1];
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_mask  = mask_reg[DEPTH-1];
  assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// Device-side model of the 256Kx16 SRAM: byte-laned writes, RD_LAT read pipe, DQ tri-state, counters.
// Define SRAM_PROTOCOL_CHECK_EN to build the sticky protocol checker behind proto_err.
module sram_responder import sram_pkg::*; #(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  input  logic              sram_ub_n,
  input  logic              sram_lb_n,
  input  logic              sram_we_n,
  input  logic              sram_ce_n,
  input  logic              sram_oe_n,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic [2:0]        proto_err
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int LANE_W = DATA_W / SRAM_LANES;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [SRAM_LANES-1:0] lane_n, lane_en, src_mask;
  logic [DATA_W-1:0]     src_data, drive_data;
  logic                  wr_cycle, wr_commit, rd_accept, bus_ok, drive_en;
  logic [15:0]           rd_cnt_reg, wr_cnt_reg;

  assign idx    = sram_addr[DEPTH_LOG2-1:0];
  assign lane_n = {sram_ub_n, sram_lb_n};

  generate
    if (ADDR_W > DEPTH_LOG2) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^sram_addr[ADDR_W-1:DEPTH_LOG2];
    end
  endgenerate

  assign wr_cycle  = ~sram_ce_n & ~sram_we_n;
  assign wr_commit = wr_cycle & (|lane_en);
  assign rd_accept = ~sram_ce_n & sram_we_n & (|lane_en);
  // Any of these releases the bus at once, even with pipe data pending.
  assign bus_ok    = ~rst & ~sram_ce_n & sram_we_n & ~sram_oe_n;

  // The array is gated by rst so a reset edge never commits a partial write.
  always_ff @(posedge clk) begin
    if (!rst && wr_cycle) begin
      for (int l = 0; l < SRAM_LANES; l++) begin
        if (lane_en[l]) mem[idx][l*LANE_W +: LANE_W] <= sram_dq[l*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      if (rd_accept) rd_cnt_reg <= rd_cnt_reg + 16'd1;
      if (wr_commit) wr_cnt_reg <= wr_cnt_reg + 16'd1;
    end
  end

  assign rd_cnt = rd_cnt_reg;
  assign wr_cnt = wr_cnt_reg;

  generate
    if (RD_LAT > 0) begin : g_pipe
      logic                  pipe_valid;
      logic [SRAM_LANES-1:0] pipe_mask;
      logic [DATA_W-1:0]     pipe_data;

      // Accepts require we_n=1, so a same-edge write can never collide with a capture.
      sram_rd_pipe #(.DATA_W(DATA_W), .DEPTH(RD_LAT)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (~sram_we_n),
        .in_valid (rd_accept),
        .in_mask  (lane_en),
        .in_data  (mem[idx]),
        .out_valid(pipe_valid),
        .out_mask (pipe_mask),
        .out_data (pipe_data)
      );

      assign drive_en = bus_ok & pipe_valid;
      assign src_mask = pipe_mask;
      assign src_data = pipe_data;
    end else begin : g_flow
      assign drive_en = bus_ok;
      assign src_mask = lane_en;
      assign src_data = mem[idx];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < SRAM_LANES; gi++) begin : g_lane
      assign lane_en[gi] = ~lane_n[gi];
      assign drive_data[gi*LANE_W +: LANE_W] = src_mask[gi] ? src_data[gi*LANE_W +: LANE_W] : '0;
    end
  endgenerate

  assign sram_dq = drive_en ? drive_data : 'z;

`ifdef SRAM_PROTOCOL_CHECK_EN
  logic [2:0] proto_err_reg, err_set;

  always_comb begin
    err_set                = '0;
    err_set[ERR_WR_NOLANE] = wr_cycle & ~(|lane_en);
    err_set[ERR_RD_NOLANE] = ~sram_ce_n & sram_we_n & ~sram_oe_n & ~(|lane_en);
    err_set[ERR_WE_NOCE]   = sram_ce_n & ~sram_we_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err_reg <= '0;
    else     proto_err_reg <= proto_err_reg | err_set;
  end

  assign proto_err = proto_err_reg;
`else
  assign proto_err = 3'b000;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench: three responders (RD_LAT 0, 2, 3) share one command bus; each DQ net has a pull-up
// so a released bus reads 16'hFFFF.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        ce_n, we_n, oe_n, ub_n, lb_n;
  logic        drv_en;
  logic [15:0] drv_data;

  tri1 [15:0] dq0, dq2, dq3;
  wire [15:0] rd_cnt0, wr_cnt0, rd_cnt2, wr_cnt2, rd_cnt3, wr_cnt3;
  wire [2:0]  perr0, perr2, perr3;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] s0, s2, s3;

  localparam logic [15:0] REL = 16'hFFFF;
`ifdef SRAM_PROTOCOL_CHECK_EN
  localparam logic [2:0] EXP_WE_NOCE = 3'b100;
`else
  localparam logic [2:0] EXP_WE_NOCE = 3'b000;
`endif

  always #5 clk = ~clk;

  assign dq0 = drv_en ? drv_data : 'z;
  assign dq2 = drv_en ? drv_data : 'z;
  assign dq3 = drv_en ? drv_data : 'z;

  sram_responder #(.RD_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .sram_addr(addr), .sram_dq(dq0), .sram_ub_n(ub_n), .sram_lb_n(lb_n),
    .sram_we_n(we_n), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0),
    .proto_err(perr0));
  sram_responder #(.RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .sram_addr(addr), .sram_dq(dq2), .sram_ub_n(ub_n), .sram_lb_n(lb_n),
    .sram_we_n(we_n), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2),
    .proto_err(perr2));
  sram_responder #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .sram_addr(addr), .sram_dq(dq3), .sram_ub_n(ub_n), .sram_lb_n(lb_n),
    .sram_we_n(we_n), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3),
    .proto_err(perr3));

  // One bus cycle: drive inputs just after an edge, sample DQ mid-cycle, then advance past the next edge.
  task automatic bus(input logic c, input logic w, input logic o, input logic u, input logic l,
                     input logic [17:0] a, input logic de, input logic [15:0] d);
    ce_n = c; we_n = w; oe_n = o; ub_n = u; lb_n = l; addr = a; drv_en = de; drv_data = d;
    #2;
    s0 = dq0; s2 = dq2; s3 = dq3;
    $display("txn t=%0t rst=%b ce_n=%b we_n=%b oe_n=%b ub_n=%b lb_n=%b addr=%h dq0=%h dq2=%h dq3=%h",
             $time, rst, c, w, o, u, l, a, s0, s2, s3);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic u, input logic l);
    bus(1'b0, 1'b0, 1'b1, u, l, a, 1'b1, d);
  endtask

  task automatic rd(input logic [17:0] a);
    bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 1'b0, 16'h0000);
  endtask

  task automatic drain();
    bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 18'h0, 1'b0, 16'h0000);
  endtask

  task automatic idle();
    bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 16'h0000);
  endtask

  task automatic test_reset();
    rd(18'h00400);
    checks++; if ({s0, s2, s3} !== {REL, REL, REL}) begin failures++;
      $display("FAIL reset_dq dq0=%h dq2=%h dq3=%h expected all %h", s0, s2, s3, REL); end
    checks++; if ({rd_cnt0, wr_cnt0, rd_cnt3, wr_cnt3} !== 64'h0) begin failures++;
      $display("FAIL reset_cnt rd0=%h wr0=%h rd3=%h wr3=%h expected 0", rd_cnt0, wr_cnt0, rd_cnt3, wr_cnt3); end
    checks++; if ({perr0, perr2, perr3} !== 9'h0) begin failures++;
      $display("FAIL reset_perr got %b/%b/%b expected 000", perr0, perr2, perr3); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    wr(18'h00400, 16'hBEEF, 1'b0, 1'b0);
    rd(18'h00400);
    checks++; if (s0 !== 16'hBEEF) begin failures++;
      $display("FAIL basic_read got %h expected BEEF", s0); end
    checks++; if (s2 !== REL) begin failures++;
      $display("FAIL basic_lat2_idle got %h expected %h", s2, REL); end
    checks++; if (wr_cnt0 !== 16'd1 || rd_cnt0 !== 16'd1) begin failures++;
      $display("FAIL basic_cnt wr=%0d rd=%0d expected 1/1", wr_cnt0, rd_cnt0); end
  endtask

  task automatic test_lanes();
    wr(18'h00012, 16'hAAAA, 1'b0, 1'b0);
    wr(18'h00012, 16'h1234, 1'b0, 1'b1);
    rd(18'h00012);
    checks++; if (s0 !== 16'h12AA) begin failures++;
      $display("FAIL lane_upper got %h expected 12AA", s0); end
    wr(18'h00012, 16'hAAAA, 1'b0, 1'b0);
    wr(18'h00012, 16'h1234, 1'b1, 1'b0);
    rd(18'h00012);
    checks++; if (s0 !== 16'hAA34) begin failures++;
      $display("FAIL lane_lower got %h expected AA34", s0); end
    bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'h00012, 1'b0, 16'h0);
    checks++; if (s0 !== 16'h0034) begin failures++;
      $display("FAIL lane_read_mask got %h expected 0034", s0); end
    wr(18'h01012, 16'h5A5A, 1'b0, 1'b0);
    rd(18'h00012);
    checks++; if (s0 !== 16'h5A5A) begin failures++;
      $display("FAIL alias got %h expected 5A5A", s0); end
    checks++; if (wr_cnt0 !== 16'd6 || rd_cnt0 !== 16'd5) begin failures++;
      $display("FAIL lane_cnt wr=%0d rd=%0d expected 6/5", wr_cnt0, rd_cnt0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e0 [7];
    logic [15:0] e2 [7];
    logic [15:0] e3 [7];
    e0 = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h0, 16'h0, 16'h0};
    e2 = '{REL, REL, 16'h0, 16'h1, 16'h2, 16'h3, REL};
    e3 = '{REL, REL, REL, 16'h0, 16'h1, 16'h2, 16'h3};
    for (int i = 0; i < 4; i++) wr(18'(i), 16'(i), 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      if (k < 4) rd(18'(k)); else drain();
      checks++; if ({s0, s2, s3} !== {e0[k], e2[k], e3[k]}) begin failures++;
        $display("FAIL b2b cycle %0d got %h/%h/%h expected %h/%h/%h", k, s0, s2, s3, e0[k], e2[k], e3[k]); end
    end
    checks++; if (wr_cnt2 !== 16'd10 || rd_cnt2 !== 16'd9) begin failures++;
      $display("FAIL b2b_cnt wr=%0d rd=%0d expected 10/9", wr_cnt2, rd_cnt2); end
  endtask

  task automatic test_write_then_read();
    logic [15:0] e0 [7];
    logic [15:0] e2 [7];
    logic [15:0] e3 [7];
    logic [17:0] ra [4];
    e0 = '{16'hC0DE, 16'h7E57, 16'hC0DE, 16'h7E57, 16'h0, 16'h0, 16'h0};
    e2 = '{REL, REL, 16'hC0DE, 16'h7E57, 16'hC0DE, 16'h7E57, REL};
    e3 = '{REL, REL, REL, 16'hC0DE, 16'h7E57, 16'hC0DE, 16'h7E57};
    ra = '{18'h20, 18'h21, 18'h20, 18'h21};
    rd(18'h0);
    rd(18'h1);
    bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h20, 1'b1, 16'hC0DE);
    checks++; if ({s0, s2, s3} !== {3{16'hC0DE}}) begin failures++;
      $display("FAIL wtr_release0 got %h/%h/%h expected C0DE", s0, s2, s3); end
    bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h21, 1'b1, 16'h7E57);
    checks++; if ({s0, s2, s3} !== {3{16'h7E57}}) begin failures++;
      $display("FAIL wtr_release1 got %h/%h/%h expected 7E57", s0, s2, s3); end
    for (int k = 0; k < 7; k++) begin
      if (k < 4) rd(ra[k]); else drain();
      checks++; if ({s0, s2, s3} !== {e0[k], e2[k], e3[k]}) begin failures++;
        $display("FAIL wtr cycle %0d got %h/%h/%h expected %h/%h/%h", k, s0, s2, s3, e0[k], e2[k], e3[k]); end
    end
    checks++; if (wr_cnt3 !== 16'd12 || rd_cnt3 !== 16'd15) begin failures++;
      $display("FAIL wtr_cnt wr=%0d rd=%0d expected 12/15", wr_cnt3, rd_cnt3); end
  endtask

  task automatic test_turnaround();
    for (int k = 0; k < 3; k++) rd(18'h20);
    bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'h20, 1'b0, 16'h0);
    checks++; if ({s0, s2, s3} !== {REL, REL, REL}) begin failures++;
      $display("FAIL ta_we_release got %h/%h/%h expected %h", s0, s2, s3, REL); end
    drain();
    checks++; if ({s2, s3} !== {REL, REL}) begin failures++;
      $display("FAIL ta_flush got %h/%h expected %h", s2, s3, REL); end
    bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h20, 1'b0, 16'h0);
    checks++; if (s0 !== REL) begin failures++;
      $display("FAIL ta_oe_release got %h expected %h", s0, REL); end
    rd(18'h20);
    checks++; if (s0 !== 16'hC0DE) begin failures++;
      $display("FAIL ta_unchanged got %h expected C0DE", s0); end
    checks++; if (wr_cnt0 !== 16'd12 || rd_cnt0 !== 16'd20) begin failures++;
      $display("FAIL ta_cnt wr=%0d rd=%0d expected 12/20", wr_cnt0, rd_cnt0); end
  endtask

  task automatic test_reset_mid_read();
    rd(18'h20);
    rd(18'h21);
    rd(18'h20);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0; addr = 18'h21; drv_en = 1'b0;
    #2;
    checks++; if (dq3 !== 16'hC0DE || dq2 !== 16'h7E57) begin failures++;
      $display("FAIL rst_pre_full got %h/%h expected C0DE/7E57", dq3, dq2); end
    rst = 1'b1;
    #1;
    checks++; if ({dq0, dq2, dq3} !== {REL, REL, REL}) begin failures++;
      $display("FAIL rst_release got %h/%h/%h expected %h", dq0, dq2, dq3, REL); end
    checks++; if ({rd_cnt0, wr_cnt0, rd_cnt3, wr_cnt3} !== 64'h0) begin failures++;
      $display("FAIL rst_cnt rd0=%h wr0=%h rd3=%h wr3=%h expected 0", rd_cnt0, wr_cnt0, rd_cnt3, wr_cnt3); end
    @(posedge clk);
    #1;
    wr(18'h20, 16'hDEAD, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drain();
      checks++; if ({s2, s3} !== {REL, REL}) begin failures++;
        $display("FAIL rst_stale cycle %0d got %h/%h expected %h", k, s2, s3, REL); end
    end
    rd(18'h20);
    checks++; if (s0 !== 16'hC0DE) begin failures++;
      $display("FAIL rst_no_write got %h expected C0DE", s0); end
    checks++; if (wr_cnt0 !== 16'd0 || rd_cnt0 !== 16'd1) begin failures++;
      $display("FAIL rst_cnt_after wr=%0d rd=%0d expected 0/1", wr_cnt0, rd_cnt0); end
  endtask

  task automatic test_protocol();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++; if ({perr0, perr2, perr3} !== 9'h0) begin failures++;
      $display("FAIL perr_clear got %b/%b/%b expected 000", perr0, perr2, perr3); end
    bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 18'h20, 1'b1, 16'h0BAD);
    checks++; if (perr0 !== EXP_WE_NOCE) begin failures++;
      $display("FAIL perr_we_noce got %b expected %b", perr0, EXP_WE_NOCE); end
    checks++; if (wr_cnt0 !== 16'd0) begin failures++;
      $display("FAIL perr_wr_cnt got %0d expected 0", wr_cnt0); end
    idle();
    idle();
    rd(18'h20);
    checks++; if (s0 !== 16'hC0DE) begin failures++;
      $display("FAIL perr_array got %h expected C0DE", s0); end
    checks++; if (perr3 !== EXP_WE_NOCE || perr0 !== EXP_WE_NOCE) begin failures++;
      $display("FAIL perr_sticky got %b/%b expected %b", perr0, perr3, EXP_WE_NOCE); end
  endtask

  initial begin
    rst = 1'b1;
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    addr = '0; drv_en = 1'b0; drv_data = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_lanes();
    test_back_to_back();
    test_write_then_read();
    test_turnaround();
    test_reset_mid_read();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t expected bench completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
